// File: rtl/memory_access_stage_pkg.sv
// Shared processor types for the EX/MEM and MEM/WB pipeline registers.
// The field widths and the bubble constants are defined here.
package memory_access_stage_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;

  typedef struct packed {
    logic              regWrite;
    logic              memToReg;
    logic              memWrite;
    logic [DATA_W-1:0] aluOut;
    logic [DATA_W-1:0] writeData;
    logic [REG_W-1:0]  writeReg;
  } exMemT;

  typedef struct packed {
    logic              regWrite;
    logic              memToReg;
    logic [DATA_W-1:0] readData;
    logic [DATA_W-1:0] aluOut;
    logic [REG_W-1:0]  writeReg;
  } memWbT;

  localparam exMemT EX_MEM_BUBBLE = '0;
  localparam memWbT MEM_WB_BUBBLE = '0;

endpackage

// File: rtl/memory_access_stage_if.sv
// Execute-side inputs, hazard controls and M/W outputs of the memory stage.
// The master modport belongs to the upstream pipeline; the stage uses slave.
interface memory_access_stage_if;
  import memory_access_stage_pkg::*;

  logic              regWriteE;
  logic              memToRegE;
  logic              memWriteE;
  logic [DATA_W-1:0] AluOutE;
  logic [DATA_W-1:0] writeDataE;
  logic [REG_W-1:0]  writeRegE;
  logic              stallM;
  logic              flushM;

  logic              regWriteM;
  logic [DATA_W-1:0] aluOutM;
  logic [REG_W-1:0]  writeRegM;
  logic              regWriteW;
  logic              memToRegW;
  logic [DATA_W-1:0] readDataW;
  logic [DATA_W-1:0] aluOutW;
  logic [REG_W-1:0]  writeRegW;
  logic [DATA_W-1:0] resultW;

  modport master (
    output regWriteE, memToRegE, memWriteE, AluOutE, writeDataE, writeRegE,
    output stallM, flushM,
    input  regWriteM, aluOutM, writeRegM,
    input  regWriteW, memToRegW, readDataW, aluOutW, writeRegW, resultW
  );

  modport slave (
    input  regWriteE, memToRegE, memWriteE, AluOutE, writeDataE, writeRegE,
    input  stallM, flushM,
    output regWriteM, aluOutM, writeRegM,
    output regWriteW, memToRegW, readDataW, aluOutW, writeRegW, resultW
  );

endinterface

// File: rtl/memory_access_stage_data_memory.sv
// Word-addressed data memory: combinational read, write on rising clk.
// A read of the word being written returns the old contents.
module data_memory
  import memory_access_stage_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] rd
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wd;
  end

  assign rd = mem[addr];

endmodule

// File: rtl/memory_access_stage.sv
// MEM pipeline stage: EX/MEM register, data memory access, MEM/WB register
// and the writeback result mux.
module memory_access_stage
  import memory_access_stage_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  memory_access_stage_if.slave bus
);

  exMemT             exMem;
  memWbT             memWb;
  logic [DATA_W-1:0] readDataM;
  logic [AW-1:0]     wordAddr;
  logic              memWe;

  // Stall takes priority over flush: the held M instruction must not be lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exMem <= EX_MEM_BUBBLE;
    end else if (!bus.stallM) begin
      if (bus.flushM) begin
        exMem <= EX_MEM_BUBBLE;
      end else begin
        exMem <= '{regWrite:  bus.regWriteE,
                   memToReg:  bus.memToRegE,
                   memWrite:  bus.memWriteE,
                   aluOut:    bus.AluOutE,
                   writeData: bus.writeDataE,
                   writeReg:  bus.writeRegE};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      memWb <= MEM_WB_BUBBLE;
    end else if (bus.stallM) begin
      memWb <= MEM_WB_BUBBLE;
    end else begin
      memWb <= '{regWrite: exMem.regWrite,
                 memToReg: exMem.memToReg,
                 readData: readDataM,
                 aluOut:   exMem.aluOut,
                 writeReg: exMem.writeReg};
    end
  end

  // Byte offset and bits above the array size are dropped, so addresses wrap.
  assign wordAddr = exMem.aluOut[AW+1:2];
  assign memWe    = exMem.memWrite & ~bus.stallM & ~reset;

  data_memory #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_dataMemory (
    .clk  (clk),
    .we   (memWe),
    .addr (wordAddr),
    .wd   (exMem.writeData),
    .rd   (readDataM)
  );

  assign bus.regWriteM = exMem.regWrite;
  assign bus.aluOutM   = exMem.aluOut;
  assign bus.writeRegM = exMem.writeReg;

  assign bus.regWriteW = memWb.regWrite;
  assign bus.memToRegW = memWb.memToReg;
  assign bus.readDataW = memWb.readData;
  assign bus.aluOutW   = memWb.aluOut;
  assign bus.writeRegW = memWb.writeReg;
  assign bus.resultW   = memWb.memToReg ? memWb.readData : memWb.aluOut;

endmodule

// File: tb/tb_memory_access_stage.sv
// Scoreboarded bench: the driver queues expected M/W values tagged with the
// cycle they should appear; a negedge monitor compares them against the DUT.
module tb_memory_access_stage;

  logic        clk = 1'b0;
  logic        reset;
  int unsigned cyc = 0;
  int          checks = 0;
  int          passes = 0;

  memory_access_stage_if bus();

  memory_access_stage #(
    .DEPTH (64),
    .AW    (6)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    logic        rw;
    logic [31:0] alu;
    logic [4:0]  wr;
  } mExpT;

  typedef struct {
    int unsigned cyc;
    logic        rw;
    logic        m2r;
    logic [4:0]  wr;
    logic [31:0] alu;
    logic [31:0] res;
    logic        chkRd;
    logic [31:0] rd;
  } wExpT;

  mExpT mQ[$];
  wExpT wQ[$];

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s got=%h want=%h", nm, got, want);
  endtask

  task automatic pushM(input int unsigned c, input logic rw, input logic [31:0] alu,
                       input logic [4:0] wr);
    mExpT e;
    e.cyc = c; e.rw = rw; e.alu = alu; e.wr = wr;
    mQ.push_back(e);
  endtask

  task automatic pushW(input int unsigned c, input logic rw, input logic m2r,
                       input logic [4:0] wr, input logic [31:0] alu, input logic [31:0] res,
                       input logic chkRd, input logic [31:0] rd);
    wExpT e;
    e.cyc = c; e.rw = rw; e.m2r = m2r; e.wr = wr; e.alu = alu;
    e.res = res; e.chkRd = chkRd; e.rd = rd;
    wQ.push_back(e);
  endtask

  always @(negedge clk) begin
    for (int i = int'(mQ.size()) - 1; i >= 0; i--) begin
      if (mQ[i].cyc == cyc) begin
        chk($sformatf("M@%0d", cyc),
            128'({bus.regWriteM, bus.aluOutM, bus.writeRegM}),
            128'({mQ[i].rw, mQ[i].alu, mQ[i].wr}));
        mQ.delete(i);
      end else if (mQ[i].cyc < cyc) begin
        checks++;
        $display("FAIL M-missed tag=%0d now=%0d", mQ[i].cyc, cyc);
        mQ.delete(i);
      end
    end
    for (int i = int'(wQ.size()) - 1; i >= 0; i--) begin
      if (wQ[i].cyc == cyc) begin
        chk($sformatf("W@%0d", cyc),
            128'({bus.regWriteW, bus.memToRegW, bus.writeRegW, bus.aluOutW, bus.resultW,
                  (wQ[i].chkRd ? bus.readDataW : 32'h0)}),
            128'({wQ[i].rw, wQ[i].m2r, wQ[i].wr, wQ[i].alu, wQ[i].res,
                  (wQ[i].chkRd ? wQ[i].rd : 32'h0)}));
        wQ.delete(i);
      end else if (wQ[i].cyc < cyc) begin
        checks++;
        $display("FAIL W-missed tag=%0d now=%0d", wQ[i].cyc, cyc);
        wQ.delete(i);
      end
    end
  end

  task automatic drive(input logic rw, input logic m2r, input logic mw,
                       input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wr,
                       input logic stall, input logic flush);
    bus.regWriteE  = rw;
    bus.memToRegE  = m2r;
    bus.memWriteE  = mw;
    bus.AluOutE    = alu;
    bus.writeDataE = wd;
    bus.writeRegE  = wr;
    bus.stallM     = stall;
    bus.flushM     = flush;
  endtask

  // One instruction per cycle; rd is the hand-computed load data when chkRd=1.
  task automatic issue(input logic rw, input logic m2r, input logic mw,
                       input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wr,
                       input logic chkRd, input logic [31:0] rd);
    @(posedge clk); #1;
    drive(rw, m2r, mw, alu, wd, wr, 1'b0, 1'b0);
    pushM(cyc + 1, rw, alu, wr);
    pushW(cyc + 2, rw, m2r, wr, alu, m2r ? rd : alu, chkRd, rd);
  endtask

  task automatic nop();
    issue(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0);
  endtask

  task automatic checkAllZero(input string nm);
    chk(nm, 128'({bus.regWriteM, bus.aluOutM, bus.writeRegM, bus.regWriteW, bus.memToRegW,
                  bus.writeRegW}), 128'd0);
    chk({nm, "-data"}, 128'({bus.readDataW, bus.aluOutW, bus.resultW}), 128'd0);
  endtask

  initial begin
    int unsigned n;
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
    #3;
    checkAllZero("reset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // store 0xDEADBEEF to 8, then load 8 into r3
    issue(1'b0, 1'b0, 1'b1, 32'd8, 32'hDEADBEEF, 5'd0, 1'b0, 32'd0);
    issue(1'b1, 1'b1, 1'b0, 32'd8, 32'd0, 5'd3, 1'b1, 32'hDEADBEEF);
    // ALU result 22 into r5
    issue(1'b1, 1'b0, 1'b0, 32'd22, 32'd0, 5'd5, 1'b0, 32'd0);
    // address wrap: 260 maps to the same word as 4 and 7
    issue(1'b0, 1'b0, 1'b1, 32'd4, 32'h11, 5'd0, 1'b0, 32'd0);
    issue(1'b0, 1'b0, 1'b1, 32'd260, 32'h22, 5'd0, 1'b0, 32'd0);
    issue(1'b1, 1'b1, 1'b0, 32'd4, 32'd0, 5'd6, 1'b1, 32'h22);
    issue(1'b1, 1'b1, 1'b0, 32'd7, 32'd0, 5'd7, 1'b1, 32'h22);

    // flushed store must not reach memory or carry regWrite
    issue(1'b0, 1'b0, 1'b1, 32'd16, 32'h77, 5'd0, 1'b0, 32'd0);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b1, 32'd16, 32'h99, 5'd9, 1'b0, 1'b1);
    pushM(cyc + 1, 1'b0, 32'd0, 5'd0);
    pushW(cyc + 2, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 32'd0);
    issue(1'b1, 1'b1, 1'b0, 32'd16, 32'd0, 5'd8, 1'b1, 32'h77);

    // store 0x55 to 12 held in M for two stalled cycles
    @(posedge clk); #1;
    n = cyc;
    drive(1'b0, 1'b0, 1'b1, 32'd12, 32'h55, 5'd0, 1'b0, 1'b0);
    pushM(n + 1, 1'b0, 32'd12, 5'd0);
    pushM(n + 2, 1'b0, 32'd12, 5'd0);
    pushM(n + 3, 1'b0, 32'd12, 5'd0);
    pushW(n + 2, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 32'd0);
    pushW(n + 3, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 32'd0);
    pushW(n + 4, 1'b0, 1'b0, 5'd0, 32'd12, 32'd12, 1'b0, 32'd0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b0);
    @(posedge clk); #1;
    nop();
    issue(1'b1, 1'b1, 1'b0, 32'd12, 32'd0, 5'd10, 1'b1, 32'h55);

    // asynchronous reset while a store sits in M: the store is lost
    issue(1'b0, 1'b0, 1'b1, 32'd20, 32'h33, 5'd0, 1'b0, 32'd0);
    issue(1'b1, 1'b1, 1'b0, 32'd8, 32'd0, 5'd4, 1'b0, 32'd0);
    issue(1'b0, 1'b0, 1'b1, 32'd20, 32'hAB, 5'd0, 1'b0, 32'd0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
    chk("preRst", 128'({bus.regWriteW, bus.writeRegW, bus.resultW, bus.aluOutM}),
        128'({1'b1, 5'd4, 32'hDEADBEEF, 32'd20}));
    #1 reset = 1'b1;
    mQ.delete();
    wQ.delete();
    #1;
    checkAllZero("asyncRst");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    issue(1'b1, 1'b1, 1'b0, 32'd20, 32'd0, 5'd11, 1'b1, 32'h33);
    issue(1'b1, 1'b1, 1'b0, 32'd8, 32'd0, 5'd12, 1'b1, 32'hDEADBEEF);

    repeat (3) nop();
    repeat (3) @(posedge clk);
    #1;
    chk("drain", 128'(mQ.size() + wQ.size()), 128'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/memory_access_stage.md
MEMORY_ACCESS_STAGE -- requirements
Module: memory_access_stage

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning the number of 32-bit data memory words (power of two).
REQ-002 SHALL have parameter AW, default 6, meaning the word-address width, equal to log2(DEPTH).
REQ-003 SHALL have port clk  input  1  the single rising-edge clock.
REQ-004 SHALL have port reset  input  1  the reset; asynchronous, active-high.
REQ-005 SHALL have port regWriteE  input  1  register-write control from the execute stage.
REQ-006 SHALL have port memToRegE  input  1  selects memory data as the writeback result.
REQ-007 SHALL have port memWriteE  input  1  data memory store enable.
REQ-008 SHALL have port AluOutE  input  32  ALU result, used as the byte address for loads and stores.
REQ-009 SHALL have port writeDataE  input  32  store data (forwarded Rt value).
REQ-010 SHALL have port writeRegE  input  5  destination register number.
REQ-011 SHALL have port stallM  input  1  holds the EX/MEM register and injects a bubble into MEM/WB.
REQ-012 SHALL have port flushM  input  1  loads a bubble into the EX/MEM register.
REQ-013 SHALL have port regWriteM, aluOutM, writeRegM  output  1/32/5  current M-stage values, for the forwarding unit.
REQ-014 SHALL have port regWriteW, memToRegW  output  1/1  writeback controls.
REQ-015 SHALL have port readDataW, aluOutW  output  32/32  registered load data and ALU result.
REQ-016 SHALL have port writeRegW  output  5  writeback destination register.
REQ-017 SHALL have port resultW  output  32  the writeback value.

Function
REQ-018 SHALL capture the E-side inputs into the EX/MEM register on each rising clk edge when stallM=0 and flushM=0.
REQ-019 SHALL, when flushM=1 and stallM=0, load regWrite=0, memToReg=0, memWrite=0, and all data and register fields=0 into EX/MEM.
REQ-020 SHALL, when stallM=1, hold EX/MEM unchanged (stall overrides flush), suppress the memory write, and load a bubble (all fields 0) into MEM/WB.
REQ-021 SHALL read memory combinationally at word index aluOutM[AW+1:2], ignoring bits [1:0] and the bits above AW+1 (address wraps modulo DEPTH).
REQ-022 SHALL write writeDataM to that same index on the rising edge that ends the M cycle, when memWriteM=1 and stallM=0.
REQ-023 SHALL, on a load that hits the word a store in the same M cycle writes, return the old contents (read-before-write).
REQ-024 SHALL capture regWriteM, memToRegM, aluOutM, writeRegM and the read data into MEM/WB on each edge when stallM=0.
REQ-025 SHALL drive resultW = memToRegW ? readDataW : aluOutW combinationally.
REQ-026 SHALL have a latency from E inputs to W outputs of 2 edges; store data is visible to a load issued one cycle later.
REQ-027 SHALL not let a store alter regWriteW or writeRegW, since the control bits pass through unmodified.

Reset
REQ-028 SHALL asynchronously clear every EX/MEM and MEM/WB field to 0 while reset=1, so that all M and W outputs and resultW are 0.
REQ-029 SHALL not reset the memory array, and SHALL suppress writes while reset=1.
REQ-030 SHALL act as a bubble if reset is asserted mid-store, so that a store not yet clocked is lost.

Structure
REQ-031 SHALL place the pipeline-register field widths (data 32, register number 5) and the bubble constant in the shared processor package.
REQ-032 SHALL implement the storage as one sub-module, data_memory (clk, we, addr, wd, rd), with DEPTH and AW parameters.

Verification
REQ-033 SHALL cover: store AluOutE=8, writeDataE=0xDEADBEEF, memWriteE=1, then a load of address 8 with memToRegE=1 and regWriteE=1, writeRegE=3 -> 2 edges after the load, readDataW=0xDEADBEEF, resultW=0xDEADBEEF, writeRegW=3.
REQ-034 SHALL cover: an ALU instruction with AluOutE=22, memToRegE=0, regWriteE=1, writeRegE=5 -> after 1 edge aluOutM=22; after 2 edges resultW=22, regWriteW=1.
REQ-035 SHALL cover: a store of 0x11 to address 4, then a store of 0x22 to address 260 (wraps to word 1) -> a load of address 4 returns 0x22; a load of address 7 also returns 0x22.
REQ-036 SHALL cover: stallM=1 for 2 cycles during a store of 0x55 to address 12 -> EX/MEM holds, MEM/WB shows bubbles with regWriteW=0, the write occurs once after release, and a later load returns 0x55.
REQ-037 SHALL cover: flushM=1 with a store of 0x99 to address 16 at E -> address 16 retains its previous value and regWriteM=0.
REQ-038 SHALL cover: reset asserted asynchronously mid-cycle -> all M and W outputs are 0 immediately, before the next clk edge.
